// File: rtl/stream_out_drain_pkg.sv
// Shared stream definitions: the 128-bit data / 16-bit parity widths, the
// buffered beat layout, and the byte-parity helpers used by the drain block.
package stream_out_drain_pkg;

  localparam int DATA_W = 128;
  localparam int PAR_W  = DATA_W / 8;

  // A buffered beat is the data word plus its computed parity-error flag.
  typedef struct packed {
    logic              perr;
    logic [DATA_W-1:0] data;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  // Skid-buffer occupancy.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Per-byte parity error: bit i is set when byte i, its parity bit and the
  // odd/even selector do not XOR to zero.
  function automatic logic [PAR_W-1:0] byte_perr(
    input logic [DATA_W-1:0] data,
    input logic [PAR_W-1:0]  par,
    input logic              odd
  );
    logic [PAR_W-1:0] err;
    err = '0;
    for (int i = 0; i < PAR_W; i++) begin
      err[i] = (^data[i*8 +: 8]) ^ par[i] ^ odd;
    end
    return err;
  endfunction

  // Beat-level parity error: any byte in error flags the whole beat.
  function automatic logic beat_perr(
    input logic [DATA_W-1:0] data,
    input logic [PAR_W-1:0]  par,
    input logic              odd
  );
    return |byte_perr(data, par, odd);
  endfunction

endpackage

// File: rtl/stream_out_drain_if.sv
// Bundles the FIFO read side and the stream output side of the drain block.
// master: the drain block itself; slave: the FIFO/consumer environment.
interface stream_out_drain_if;
  import stream_out_drain_pkg::*;

  // FIFO read side (first-word-fall-through)
  logic [DATA_W-1:0] fifo_dout;
  logic [PAR_W-1:0]  fifo_doutp;
  logic              fifo_empty;
  logic              fifo_rd_en;

  // Stream output side
  logic              s_out_valid;
  logic              s_out_rdy;
  logic [DATA_W-1:0] s_out_data;
  logic              s_out_perr;

  modport master (
    input  fifo_dout,
    input  fifo_doutp,
    input  fifo_empty,
    output fifo_rd_en,
    output s_out_valid,
    input  s_out_rdy,
    output s_out_data,
    output s_out_perr
  );

  modport slave (
    output fifo_dout,
    output fifo_doutp,
    output fifo_empty,
    input  fifo_rd_en,
    input  s_out_valid,
    output s_out_rdy,
    input  s_out_data,
    input  s_out_perr
  );

endinterface

// File: rtl/skid_buf_2.sv
// Two-entry skid buffer. Entry 0 is always the head; a pop with a second
// entry present shifts entry 1 forward, and a push lands in the first slot
// that is free after this cycle's pop. Pushing into an empty buffer (or into
// a single-entry buffer that is popping) writes the head directly, so a
// pushed word is visible on head_o right after the capturing edge.
module skid_buf_2
  import stream_out_drain_pkg::*;
#(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic         full_o,
  output logic [W-1:0] head_o
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic         pop_ok;
  logic         push_ok;
  logic         push_to_head;

  // Ignore pops of an empty buffer and pushes that would overflow it.
  assign pop_ok       = pop_i && (occ_q != OCC_EMPTY);
  assign push_ok      = push_i && ((occ_q != OCC_FULL) || pop_ok);
  assign push_to_head = (occ_q == OCC_EMPTY) || ((occ_q == OCC_ONE) && pop_ok);

  // Next occupancy: current count plus push minus pop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    occ_d = occ_q;
    case ({push_ok, pop_ok})
      2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_d = (occ_q == OCC_FULL)  ? OCC_ONE : OCC_EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  // Next payload: shift forward on pop at full, then write the free slot.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (pop_ok && (occ_q == OCC_FULL)) begin
      ent0_d = ent1_q;
    end
    if (push_ok) begin
      if (push_to_head) begin
        ent0_d = push_data_i;
      end else begin
        ent1_d = push_data_i;
      end
    end
  end

  // Occupancy register; clearing it is what discards buffered beats on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values regardless of block order.
    if (!rst_n) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Payload registers.
  // NOTE: the payload storage is deliberately left without reset; occupancy
  // alone qualifies its contents, which keeps the wide datapath reset-free.
  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assign valid_o = (occ_q != OCC_EMPTY);
  assign full_o  = (occ_q == OCC_FULL);
  assign head_o  = ent0_q;

endmodule

// File: rtl/stream_out_drain.sv
// Drains a first-word-fall-through FIFO onto a valid/ready stream through a
// two-entry skid buffer, checking per-byte parity on the way. Pops are
// issued combinationally whenever the buffer can absorb the word this cycle,
// giving one-cycle latency and one beat per cycle under full flow.
module stream_out_drain
  import stream_out_drain_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drain_en,
  input  logic              perr_clr,
  output logic              perr_sticky,
  output logic [CNT_W-1:0]  beat_cnt,
  stream_out_drain_if.master bus
);

  logic             buf_valid;
  logic             buf_full;
  logic [BEAT_W-1:0] buf_head;
  beat_t            head;
  beat_t            in_beat;
  logic             in_perr;
  logic             fire;
  logic             rd_en;

  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Parity check of the word currently presented by the FIFO.
  assign in_perr = beat_perr(bus.fifo_dout, bus.fifo_doutp, PARITY_ODD);
  assign in_beat = '{perr: in_perr, data: bus.fifo_dout};

  // A beat leaves on valid && ready.
  assign fire = buf_valid && bus.s_out_rdy;

  // Pop when enabled, the FIFO has data, and there is room after this
  // cycle's output beat. rst_n gates the strobe so nothing pops in reset.
  assign rd_en = rst_n && drain_en && !bus.fifo_empty && (!buf_full || fire);
  assign bus.fifo_rd_en = rd_en;

  skid_buf_2 #(
    .W (BEAT_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rd_en),
    .push_data_i (in_beat),
    .pop_i       (fire),
    .valid_o     (buf_valid),
    .full_o      (buf_full),
    .head_o      (buf_head)
  );

  assign head            = beat_t'(buf_head);
  assign bus.s_out_valid = buf_valid;
  assign bus.s_out_data  = head.data;
  assign bus.s_out_perr  = buf_valid && head.perr;

  // Next sticky flag (capture of a bad beat beats a clear) and beat count.
  always_comb begin
    sticky_d = sticky_q;
    if (rd_en && in_perr) begin
      sticky_d = 1'b1;
    end else if (perr_clr) begin
      sticky_d = 1'b0;
    end
    cnt_d = cnt_q + CNT_W'(fire);
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign perr_sticky = sticky_q;
  assign beat_cnt    = cnt_q;

endmodule

// File: tb/tb_stream_out_drain.sv
// Bench for stream_out_drain: a queue-based FIFO source, a queue model of
// the buffered beats, and per-cycle comparison of every output. A second
// instance with a 4-bit counter shares the same inputs to exercise wrap.
module tb_stream_out_drain;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  p;
  } word_t;

  typedef struct packed {
    logic [127:0] d;
    logic         e;
  } mbeat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drain_en;
  logic        perr_clr;
  logic        perr_sticky, perr_sticky4;
  logic [31:0] beat_cnt;
  logic [3:0]  beat_cnt4;

  always #5 clk = ~clk;

  stream_out_drain_if bus ();
  stream_out_drain_if bus4 ();

  assign bus4.fifo_dout  = bus.fifo_dout;
  assign bus4.fifo_doutp = bus.fifo_doutp;
  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.s_out_rdy  = bus.s_out_rdy;

  stream_out_drain #(.PARITY_ODD(1'b0), .CNT_W(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .drain_en    (drain_en),
    .perr_clr    (perr_clr),
    .perr_sticky (perr_sticky),
    .beat_cnt    (beat_cnt),
    .bus         (bus)
  );

  stream_out_drain #(.PARITY_ODD(1'b0), .CNT_W(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .drain_en    (drain_en),
    .perr_clr    (perr_clr),
    .perr_sticky (perr_sticky4),
    .beat_cnt    (beat_cnt4),
    .bus         (bus4)
  );

  // Model state
  word_t        src_q[$];
  mbeat_t       exp_q[$];
  int unsigned  exp_cnt = 0;
  logic         exp_sticky = 1'b0;
  logic [127:0] out_d[$];
  logic         out_e[$];
  int           out_cyc[$];
  logic         hold_pending = 1'b0;
  logic [127:0] hold_data = '0;

  // Stimulus knobs
  int   stall_pct = 0;
  int   empty_pct = 0;
  int   clr_pct = 0;
  int   drain_off_pct = 0;
  logic drain_mode = 1'b1;
  logic clr_now = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Even parity: the stored bit makes each byte plus its bit XOR to zero.
  function automatic word_t make_word(input logic [127:0] d, input int bad_byte);
    word_t w;
    w.d = d;
    for (int b = 0; b < 16; b++) begin
      w.p[b] = ($countones(d[b*8 +: 8]) % 2) != 0;
    end
    if (bad_byte >= 0) w.p[bad_byte] = ~w.p[bad_byte];
    return w;
  endfunction

  function automatic logic model_perr(input word_t w);
    for (int b = 0; b < 16; b++) begin
      if ((($countones(w.d[b*8 +: 8]) + int'(w.p[b])) % 2) != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_logs();
    out_d.delete();
    out_e.delete();
    out_cyc.delete();
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later, then
  // advance the model on the rising edge.
  task automatic cycle();
    logic   exp_valid, fire, exp_rd, e;
    word_t  w;
    mbeat_t nb;
    @(negedge clk);
    if (src_q.size() == 0 || ($urandom_range(99) < empty_pct)) begin
      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = rand128();
      bus.fifo_doutp = 16'($urandom);
    end else begin
      bus.fifo_empty = 1'b0;
      bus.fifo_dout  = src_q[0].d;
      bus.fifo_doutp = src_q[0].p;
    end
    bus.s_out_rdy = ($urandom_range(99) >= stall_pct);
    drain_en = drain_mode && ($urandom_range(99) >= drain_off_pct);
    perr_clr = clr_now || ($urandom_range(99) < clr_pct);
    #1;
    exp_valid = (exp_q.size() != 0);
    fire      = exp_valid && bus.s_out_rdy;
    exp_rd    = drain_en && !bus.fifo_empty && (exp_q.size() < 2 || fire);
    check("fifo_rd_en", bus.fifo_rd_en, exp_rd);
    check("s_out_valid", bus.s_out_valid, exp_valid);
    check("s_out_perr", bus.s_out_perr, exp_valid ? exp_q[0].e : 1'b0);
    if (exp_valid) check("s_out_data", bus.s_out_data, exp_q[0].d);
    check("beat_cnt", beat_cnt, exp_cnt);
    check("perr_sticky", perr_sticky, exp_sticky);
    check("fifo_rd_en_w4", bus4.fifo_rd_en, exp_rd);
    check("s_out_valid_w4", bus4.s_out_valid, exp_valid);
    if (exp_valid) check("s_out_data_w4", bus4.s_out_data, exp_q[0].d);
    check("beat_cnt_w4", beat_cnt4, exp_cnt[3:0]);
    check("perr_sticky_w4", perr_sticky4, exp_sticky);
    if (hold_pending) check("stall_hold", bus.s_out_data, hold_data);
    hold_pending = bus.s_out_valid && !bus.s_out_rdy;
    hold_data    = bus.s_out_data;
    if (bus.s_out_valid && bus.s_out_rdy) begin
      out_d.push_back(bus.s_out_data);
      out_e.push_back(bus.s_out_perr);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (fire) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    e = 1'b0;
    if (exp_rd) begin
      w    = src_q.pop_front();
      e    = model_perr(w);
      nb.d = w.d;
      nb.e = e;
      exp_q.push_back(nb);
    end
    if (exp_rd && e) exp_sticky = 1'b1;
    else if (perr_clr) exp_sticky = 1'b0;
    cyc++;
  endtask

  task automatic run_until(input int n, input int bound, input string name);
    int k = 0;
    while (out_d.size() < n && k < bound) begin
      cycle();
      k++;
    end
    check(name, out_d.size(), n);
  endtask

  initial begin
    int start;
    int errs;
    word_t sent[$];
    word_t w;

    // Reset: outputs quiet and no pop even with a willing FIFO and consumer.
    drain_en       = 1'b1;
    perr_clr       = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.fifo_dout  = 128'h1234;
    bus.fifo_doutp = 16'h0;
    bus.s_out_rdy  = 1'b1;
    @(negedge clk);
    #1;
    check("rst_valid", bus.s_out_valid, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_perr", bus.s_out_perr, 0);
    check("rst_sticky", perr_sticky, 0);
    check("rst_cnt", beat_cnt, 0);
    check("rst_rd_en_w4", bus4.fifo_rd_en, 0);
    drain_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: 600 incrementing words, always ready.
    clear_logs();
    for (int i = 0; i < 600; i++) src_q.push_back(make_word(128'(i), -1));
    start = cyc;
    run_until(600, 700, "stream_count");
    if (out_d.size() == 600) begin
      check("stream_first_latency", out_cyc[0] - start, 1);
      check("stream_rate", out_cyc[599] - out_cyc[0], 599);
      errs = 0;
      for (int i = 0; i < 600; i++) if (out_d[i] !== 128'(i)) errs++;
      check("stream_order", errs, 0);
    end
    #1;
    check("stream_beat_cnt", beat_cnt, 600);
    check("stream_sticky", perr_sticky, 0);

    // Parity: word 5 has parity bit 3 flipped.
    clear_logs();
    for (int i = 0; i < 20; i++) src_q.push_back(make_word(128'(1000 + i), (i == 5) ? 3 : -1));
    run_until(20, 60, "parity_count");
    if (out_d.size() == 20) begin
      check("parity_beat5", out_e[5], 1);
      errs = 0;
      for (int i = 0; i < 20; i++) if (out_e[i]) errs++;
      check("parity_only_one", errs, 1);
    end
    #1;
    check("parity_sticky_set", perr_sticky, 1);
    clr_now = 1'b1;
    cycle();
    clr_now = 1'b0;
    cycle();
    #1;
    check("parity_sticky_clr", perr_sticky, 0);

    // Set/clear collision: clear is high on the capture of a bad beat.
    clear_logs();
    src_q.push_back(make_word(128'hDEAD_BEEF, 7));
    clr_now = 1'b1;
    cycle();
    clr_now = 1'b0;
    #1;
    check("collide_sticky", perr_sticky, 1);
    run_until(1, 10, "collide_count");
    clr_now = 1'b1;
    cycle();
    clr_now = 1'b0;
    #1;
    check("collide_sticky_clr", perr_sticky, 0);

    // Backpressure with random stalls, early empty, gating and clears.
    clear_logs();
    sent.delete();
    for (int i = 0; i < 400; i++) begin
      w = make_word(rand128(), ($urandom_range(9) == 0) ? int'($urandom_range(15)) : -1);
      sent.push_back(w);
      src_q.push_back(w);
    end
    stall_pct = 30;
    empty_pct = 15;
    clr_pct = 5;
    drain_off_pct = 10;
    run_until(400, 4000, "bp_count");
    stall_pct = 0;
    empty_pct = 0;
    clr_pct = 0;
    drain_off_pct = 0;
    if (out_d.size() == 400) begin
      errs = 0;
      for (int i = 0; i < 400; i++) begin
        if (out_d[i] !== sent[i].d) errs++;
        if (out_e[i] !== model_perr(sent[i])) errs++;
      end
      check("bp_order", errs, 0);
    end

    // Gating: fill two entries while stalled, then drain with drain_en low.
    clear_logs();
    for (int i = 0; i < 4; i++) src_q.push_back(make_word(128'(2000 + i), -1));
    stall_pct = 100;
    repeat (3) cycle();
    drain_mode = 1'b0;
    stall_pct = 0;
    repeat (4) cycle();
    check("gate_drained", out_d.size(), 2);
    if (out_d.size() == 2) begin
      check("gate_beat0", out_d[0], 2000);
      check("gate_beat1", out_d[1], 2001);
    end
    #1;
    check("gate_valid_low", bus.s_out_valid, 0);
    // Empty flag held high: no pop although words are waiting.
    drain_mode = 1'b1;
    empty_pct = 100;
    repeat (5) cycle();
    empty_pct = 0;
    run_until(4, 20, "gate_resume_count");
    if (out_d.size() == 4) check("gate_beat2", out_d[2], 2002);

    // Reset at occupancy 2: beats discarded, FIFO head popped first after.
    clear_logs();
    for (int i = 0; i < 3; i++) src_q.push_back(make_word(128'(3000 + i), -1));
    stall_pct = 100;
    repeat (3) cycle();
    stall_pct = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.s_out_valid, 0);
    check("midrst_rd_en", bus.fifo_rd_en, 0);
    check("midrst_cnt", beat_cnt, 0);
    check("midrst_valid_w4", bus4.s_out_valid, 0);
    bus.s_out_rdy = 1'b1;
    #1;
    check("midrst_rd_en_rdy", bus.fifo_rd_en, 0);
    exp_q.delete();
    exp_cnt = 0;
    exp_sticky = 1'b0;
    hold_pending = 1'b0;
    drain_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) src_q.push_back(make_word(128'(3100 + i), -1));
    run_until(17, 60, "wrap_count");
    if (out_d.size() >= 1) check("midrst_first_pop", out_d[0], 3002);
    #1;
    check("wrap_cnt_w4", beat_cnt4, 1);
    check("wrap_cnt_w32", beat_cnt, 17);
    run_until(18, 20, "final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop against a stuck run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
